// File: rtl/sdram_sched_pkg.sv
// ============================================================================
// Module      : sdram_sched_pkg
// Description : Shared encodings and default geometry for the SDRAM ring
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_BUSY = 2'd2
  } state_e;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } side_e;

  localparam int DEF_BURST_BYTES = 8;
  localparam int DEF_RING_BYTES  = 67108864;

endpackage

`default_nettype wire

// File: rtl/sdram_ring_scheduler_ring_pointer.sv
// ============================================================================
// Module      : ring_pointer
// Description : Byte pointer with synchronous clear and burst-sized advance
//               that wraps to zero at the ring size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_pointer
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int BURST_BYTES = DEF_BURST_BYTES,
  parameter int RING_BYTES  = DEF_RING_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] BURST_L = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] RING_L  = ADDR_W'(RING_BYTES);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_inc;

  always_comb begin
    ptr_inc = ptr_q + BURST_L;
    ptr_d   = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (adv_i) begin
      ptr_d = (ptr_inc == RING_L) ? '0 : ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/sdram_ring_scheduler.sv
// ============================================================================
// Module      : sdram_ring_scheduler
// Description : Round-robin grant of the shared MIG command port between the
//               write and read engines; owns ring pointers, fill and status.
//               Optional busy watchdog enabled by SDRAM_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_ring_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int BURST_BYTES    = DEF_BURST_BYTES,
  parameter int RING_BYTES     = DEF_RING_BYTES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              calib_done,
  input  logic              writes_en,
  input  logic              reads_en,
  input  logic              flush,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              xfer_done,
  output logic              wr_gnt,
  output logic              rd_gnt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] fill_bytes,
  output logic              ring_empty,
  output logic              ring_full,
  output logic              overflow,
  output logic              timeout
);

  localparam logic [ADDR_W-1:0] BURST_L  = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] FULL_THR = ADDR_W'(RING_BYTES - BURST_BYTES);

  if ((TIMEOUT_CYCLES < 1) || ((RING_BYTES % BURST_BYTES) != 0)) begin : g_bad_cfg
    $error("sdram_ring_scheduler: illegal parameter combination");
  end

  state_e            state_q, state_d;
  side_e             last_q, last_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              full_q, empty_q;
  logic              ovf_q, ovf_d;
  logic              fpend_q, fpend_d;
  logic              ptr_clr, wr_adv, rd_adv;
  logic              wr_ok, rd_ok, flushing, tmo_hit;

  always_comb begin
    wr_ok    = calib_done & writes_en & wr_req & ~full_q;
    rd_ok    = calib_done & reads_en & rd_req & (fill_q >= BURST_L);
    flushing = fpend_q | flush;
    state_d  = state_q;
    last_d   = last_q;
    wr_gnt_d = wr_gnt_q;
    rd_gnt_d = rd_gnt_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    fpend_d  = fpend_q;
    ptr_clr  = 1'b0;
    wr_adv   = 1'b0;
    rd_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          ptr_clr = 1'b1;
          fill_d  = '0;
          ovf_d   = 1'b0;
        end else begin
          if (calib_done & writes_en & wr_req & full_q) ovf_d = 1'b1;
          // On a tie the side not served last wins.
          if (wr_ok && (!rd_ok || last_q == READ)) begin
            state_d  = S_WR_BUSY;
            wr_gnt_d = 1'b1;
          end else if (rd_ok) begin
            state_d  = S_RD_BUSY;
            rd_gnt_d = 1'b1;
          end
        end
      end
      S_WR_BUSY, S_RD_BUSY: begin
        if (flush) fpend_d = 1'b1;
        if (xfer_done) begin
          state_d  = S_IDLE;
          wr_gnt_d = 1'b0;
          rd_gnt_d = 1'b0;
          fpend_d  = 1'b0;
          last_d   = (state_q == S_WR_BUSY) ? WRITE : READ;
          // A flush seen during the burst supersedes its pointer advance.
          if (flushing) begin
            ptr_clr = 1'b1;
            fill_d  = '0;
            ovf_d   = 1'b0;
          end else if (state_q == S_WR_BUSY) begin
            wr_adv = 1'b1;
            fill_d = fill_q + BURST_L;
          end else begin
            rd_adv = 1'b1;
            fill_d = fill_q - BURST_L;
          end
        end else if (tmo_hit) begin
          state_d  = S_IDLE;
          wr_gnt_d = 1'b0;
          rd_gnt_d = 1'b0;
          fpend_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= READ;
      wr_gnt_q <= 1'b0;
      rd_gnt_q <= 1'b0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      fpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wr_gnt_q <= wr_gnt_d;
      rd_gnt_q <= rd_gnt_d;
      fill_q   <= fill_d;
      full_q   <= (fill_d > FULL_THR);
      empty_q  <= (fill_d == '0);
      ovf_q    <= ovf_d;
      fpend_q  <= fpend_d;
    end
  end

`ifdef SDRAM_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] busy_cnt_q;
  logic             timeout_q;

  assign tmo_hit = (state_q != S_IDLE) && !xfer_done &&
                   (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      busy_cnt_q <= (state_q != S_IDLE && state_d != S_IDLE) ? busy_cnt_q + 1'b1 : '0;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  ring_pointer #(
    .ADDR_W      (ADDR_W),
    .BURST_BYTES (BURST_BYTES),
    .RING_BYTES  (RING_BYTES)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (ptr_clr),
    .adv_i (wr_adv),
    .ptr_o (wr_addr)
  );

  ring_pointer #(
    .ADDR_W      (ADDR_W),
    .BURST_BYTES (BURST_BYTES),
    .RING_BYTES  (RING_BYTES)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (ptr_clr),
    .adv_i (rd_adv),
    .ptr_o (rd_addr)
  );

  assign wr_gnt     = wr_gnt_q;
  assign rd_gnt     = rd_gnt_q;
  assign fill_bytes = fill_q;
  assign ring_full  = full_q;
  assign ring_empty = empty_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_ring_scheduler.sv
// ============================================================================
// Module      : tb_sdram_ring_scheduler
// Description : Directed vector bench for sdram_ring_scheduler on a 32-byte
//               ring; optional watchdog checked when SDRAM_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_ring_scheduler;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, calib_done, writes_en, reads_en, flush;
  logic          wr_req, rd_req, xfer_done;
  logic          wr_gnt, rd_gnt, ring_empty, ring_full, overflow, timeout;
  logic [AW-1:0] wr_addr, rd_addr, fill_bytes;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_ring_scheduler #(
    .ADDR_W         (AW),
    .BURST_BYTES    (8),
    .RING_BYTES     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .calib_done (calib_done),
    .writes_en  (writes_en),
    .reads_en   (reads_en),
    .flush      (flush),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .xfer_done  (xfer_done),
    .wr_gnt     (wr_gnt),
    .rd_gnt     (rd_gnt),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .fill_bytes (fill_bytes),
    .ring_empty (ring_empty),
    .ring_full  (ring_full),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  // in  = {calib_done, writes_en, reads_en, flush, wr_req, rd_req, xfer_done}
  // gnt = {wr_gnt, rd_gnt}; st = {ring_empty, ring_full, overflow}
  typedef struct {
    logic [6:0] in;
    logic [1:0] gnt;
    int         wa;
    int         ra;
    int         fl;
    logic [2:0] st;
  } vec_t;

  localparam int NV = 36;
  vec_t tv[NV];

  function automatic vec_t mk(input logic [6:0] in, input logic [1:0] gnt,
                              input int wa, input int ra, input int fl,
                              input logic [2:0] st);
    vec_t v;
    v.in  = in;
    v.gnt = gnt;
    v.wa  = wa;
    v.ra  = ra;
    v.fl  = fl;
    v.st  = st;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d] got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {calib_done, writes_en, reads_en, flush, wr_req, rd_req, xfer_done} = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int hi_cnt;

  initial begin
    // write-only fill
    tv[0]  = mk(7'b0100100, 2'b00,  0,  0,  0, 3'b100);
    tv[1]  = mk(7'b1100100, 2'b10,  0,  0,  0, 3'b100);
    tv[2]  = mk(7'b1100100, 2'b10,  0,  0,  0, 3'b100);
    tv[3]  = mk(7'b1100101, 2'b00,  8,  0,  8, 3'b000);
    tv[4]  = mk(7'b1100100, 2'b10,  8,  0,  8, 3'b000);
    tv[5]  = mk(7'b1100101, 2'b00, 16,  0, 16, 3'b000);
    // round robin, last served = write
    tv[6]  = mk(7'b1110110, 2'b01, 16,  0, 16, 3'b000);
    tv[7]  = mk(7'b1110111, 2'b00, 16,  8,  8, 3'b000);
    tv[8]  = mk(7'b1110110, 2'b10, 16,  8,  8, 3'b000);
    tv[9]  = mk(7'b1110111, 2'b00, 24,  8, 16, 3'b000);
    tv[10] = mk(7'b1110110, 2'b01, 24,  8, 16, 3'b000);
    tv[11] = mk(7'b1110111, 2'b00, 24, 16,  8, 3'b000);
    // wrap to full, then overflow
    tv[12] = mk(7'b1100100, 2'b10, 24, 16,  8, 3'b000);
    tv[13] = mk(7'b1100101, 2'b00,  0, 16, 16, 3'b000);
    tv[14] = mk(7'b1100100, 2'b10,  0, 16, 16, 3'b000);
    tv[15] = mk(7'b1100101, 2'b00,  8, 16, 24, 3'b000);
    tv[16] = mk(7'b1100100, 2'b10,  8, 16, 24, 3'b000);
    tv[17] = mk(7'b1100101, 2'b00, 16, 16, 32, 3'b010);
    tv[18] = mk(7'b1100100, 2'b00, 16, 16, 32, 3'b011);
    tv[19] = mk(7'b1110110, 2'b01, 16, 16, 32, 3'b011);
    tv[20] = mk(7'b1110111, 2'b00, 16, 24, 24, 3'b001);
    // idle flush blocks a grant; read starvation
    tv[21] = mk(7'b1101100, 2'b00,  0,  0,  0, 3'b100);
    tv[22] = mk(7'b1010010, 2'b00,  0,  0,  0, 3'b100);
    tv[23] = mk(7'b1010011, 2'b00,  0,  0,  0, 3'b100);
    tv[24] = mk(7'b1110110, 2'b10,  0,  0,  0, 3'b100);
    tv[25] = mk(7'b1110011, 2'b00,  8,  0,  8, 3'b000);
    tv[26] = mk(7'b1110010, 2'b01,  8,  0,  8, 3'b000);
    tv[27] = mk(7'b1110011, 2'b00,  8,  8,  0, 3'b100);
    // flush mid-burst with calib_done dropped
    tv[28] = mk(7'b1100100, 2'b10,  8,  8,  0, 3'b100);
    tv[29] = mk(7'b1100101, 2'b00, 16,  8,  8, 3'b000);
    tv[30] = mk(7'b1100100, 2'b10, 16,  8,  8, 3'b000);
    tv[31] = mk(7'b1101100, 2'b10, 16,  8,  8, 3'b000);
    tv[32] = mk(7'b0100000, 2'b10, 16,  8,  8, 3'b000);
    tv[33] = mk(7'b0100001, 2'b00,  0,  0,  0, 3'b100);
    tv[34] = mk(7'b1100100, 2'b10,  0,  0,  0, 3'b100);
    tv[35] = mk(7'b1100101, 2'b00,  8,  0,  8, 3'b000);

    reset = 1'b1;
    drive(7'b0000000);
    step();
    step();
    check("rst wr_gnt", 0, int'(wr_gnt), 0);
    check("rst rd_gnt", 0, int'(rd_gnt), 0);
    check("rst wr_addr", 0, int'(wr_addr), 0);
    check("rst rd_addr", 0, int'(rd_addr), 0);
    check("rst fill", 0, int'(fill_bytes), 0);
    check("rst status", 0, int'({ring_empty, ring_full, overflow, timeout}), 4'b1000);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].in);
      step();
      check("gnt", i, int'({wr_gnt, rd_gnt}), int'(tv[i].gnt));
      check("wr_addr", i, int'(wr_addr), tv[i].wa);
      check("rd_addr", i, int'(rd_addr), tv[i].ra);
      check("fill", i, int'(fill_bytes), tv[i].fl);
      check("status", i, int'({ring_empty, ring_full, overflow}), int'(tv[i].st));
    end

    // Ring now holds 8 bytes, wr_addr=8, rd_addr=0; grant a write and never finish it.
    drive(7'b1100100);
    step();
    check("hold gnt", 0, int'(wr_gnt), 1);
    drive(7'b1100000);
`ifdef SDRAM_SCHED_TIMEOUT_EN
    hi_cnt = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!wr_gnt) break;
      hi_cnt++;
    end
    check("tmo gnt cycles", 0, hi_cnt, 16);
    check("tmo flag", 0, int'(timeout), 1);
    check("tmo wr_addr", 0, int'(wr_addr), 8);
    check("tmo fill", 0, int'(fill_bytes), 8);
    step();
    check("tmo sticky", 0, int'(timeout), 1);
`else
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (wr_gnt) hi_cnt++;
    end
    check("no-tmo gnt cycles", 0, hi_cnt, 40);
    check("no-tmo flag", 0, int'(timeout), 0);
    drive(7'b1100001);
    step();
    check("late done gnt", 0, int'(wr_gnt), 0);
    check("late done wr_addr", 0, int'(wr_addr), 16);
    check("late done fill", 0, int'(fill_bytes), 16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdram_ring_scheduler.md
Name: sdram_ring_scheduler

Overview:
- Sequences the SDRAM ring buffer for the DDR2 read/write state machine and shares the single MIG p0 command port between the write engine (input-FIFO drain) and the read engine (output-FIFO fill).
- Owns the write/read byte pointers, their wrap-around, the fill level, and the full/empty/overflow status.
- Grants exactly one burst at a time to one engine; each engine reports completion with a done pulse.

Parameters:
- ADDR_W, 30, width of byte addresses (matches p0_cmd_byte_addr).
- BURST_BYTES, 8, bytes moved per granted burst (2 x 32-bit); power of two.
- RING_BYTES, 67108864, ring size in bytes; multiple of BURST_BYTES, at most 2^(ADDR_W-1).
- TIMEOUT_CYCLES, 1024, busy watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- calib_done  in  1  MIG calibration complete; no grants while low.
- writes_en  in  1  write path enabled.
- reads_en  in  1  read path enabled.
- flush  in  1  pulse; empties ring (pointers to 0).
- wr_req  in  1  write engine has ≥1 burst ready.
- rd_req  in  1  read engine has room for ≥1 burst.
- xfer_done  in  1  pulse; granted burst finished.
- wr_gnt  out  1  write burst granted; held until xfer_done.
- rd_gnt  out  1  read burst granted; held until xfer_done.
- wr_addr  out  ADDR_W  byte address for the current/next write burst.
- rd_addr  out  ADDR_W  byte address for the current/next read burst.
- fill_bytes  out  ADDR_W  bytes written but not yet read.
- ring_empty  out  1  fill_bytes == 0.
- ring_full  out  1  fill_bytes > RING_BYTES - BURST_BYTES.
- overflow  out  1  sticky; a write was refused because the ring was full.
- timeout  out  1  sticky watchdog flag (tied 0 unless the feature is enabled).

Behaviour:
- Reset values:
  - All outputs 0, except ring_empty = 1.
  - State S_IDLE; last_served = READ, so a write wins the first tie.
- States:
  - S_IDLE: compute eligibility.
    - wr_ok = calib_done & writes_en & wr_req & !ring_full.
    - rd_ok = calib_done & reads_en & rd_req & (fill_bytes >= BURST_BYTES).
  - Grant selection:
    - Only one eligible: grant it.
    - Both eligible: grant the one opposite last_served (round robin).
    - Granted request → S_WR_BUSY or S_RD_BUSY. Gnt is registered, so it is high the cycle after eligibility is sampled.
  - S_WR_BUSY / S_RD_BUSY: hold gnt and its address stable.
    - On xfer_done: advance that pointer by BURST_BYTES, wrapping to 0 when the result equals RING_BYTES.
    - fill_bytes ± BURST_BYTES, drop gnt, update last_served, → S_IDLE.
    - At least one idle cycle separates consecutive grants; wr_gnt and rd_gnt are never high together.
- Outputs:
  - All outputs are registered.
  - fill_bytes, ring_full and ring_empty update the cycle after xfer_done.
- Overflow: set in S_IDLE when calib_done & writes_en & wr_req & ring_full; cleared only by reset or flush.
- flush:
  - In S_IDLE: both pointers, fill_bytes and overflow clear next cycle, and no grant is issued that cycle.
  - In a busy state: latched as pending. On xfer_done, the pointer advance is discarded and the flush is applied; → S_IDLE.
- Other boundary rules:
  - xfer_done in S_IDLE is ignored.
  - Deasserting calib_done or an enable mid-burst does not abort the burst; the grant completes normally.
  - Equal pointers are disambiguated by fill_bytes: 0 means empty, RING_BYTES means full.

Optional Feature:
- Macro: SDRAM_SCHED_TIMEOUT_EN.
- With the macro: a busy-cycle counter runs in S_WR_BUSY/S_RD_BUSY.
  - When it reaches TIMEOUT_CYCLES without xfer_done: set timeout (sticky until reset), drop gnt, leave pointers and fill unchanged, → S_IDLE.
- Without the macro: no counter is built, timeout is tied 0, and busy states wait indefinitely.

Decomposition:
- Package sdram_sched_pkg holds:
  - the state encoding (S_IDLE, S_WR_BUSY, S_RD_BUSY);
  - the served-side encoding (WRITE/READ);
  - the default BURST_BYTES and RING_BYTES constants.
- One sub-module, ring_pointer:
  - ADDR_W-wide register with synchronous clear, advance-by-BURST_BYTES and wrap at RING_BYTES;
  - instantiated twice (write, read).

Test Plan:
- Write-only fill: calib_done=1, writes_en=1, wr_req held, done 2 cycles after each grant, 4 bursts → wr_addr sequence 0, 8, 16, 24 → 32; fill_bytes=32; rd_gnt never asserted.
- Round robin: fill=64, wr_req and rd_req both held → grants alternate W, R, W, R, with one idle cycle between grants and never both high.
- Wrap and full: RING_BYTES=32. Write 4 bursts → wr_addr wraps to 0, ring_full=1. A further wr_req → no grant, overflow=1. Read one burst → ring_full=0, rd_addr=8.
- Read starvation: fill=0, rd_req=1 → no rd_gnt; after one write completes, rd_gnt is asserted on the following idle evaluation.
- Flush mid-burst: flush pulsed while wr_gnt high, then xfer_done → wr_addr=0, rd_addr=0, fill=0, ring_empty=1, overflow=0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): grant with xfer_done never sent → gnt drops after 16 busy cycles, timeout=1, pointers unchanged.
